// File: rtl/kv10_mul.sv
// rtl/kv10_mul.sv - KV10 iterative signed 36x36 multiplier, PDP-10 MUL double-word format
// One shift-add step per cycle; the sign-bit step subtracts the multiplicand.
module kv10_mul #(
   parameter int width = 36
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [width-1:0] A,
   input  logic [width-1:0] M,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] result,
   output logic [width-1:0] resultlow,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(width);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [width:0]   acc_q;
   logic [width-1:0] mq_q;
   logic [width-1:0] a_q;
   logic [CW-1:0]    cnt_q;

   logic [width:0]   a_ext;
   logic [width:0]   sum_d;
   logic [width:0]   acc_d;
   logic [width-1:0] mq_d;

   always_comb begin
      a_ext = {a_q[width-1], a_q};
      sum_d = acc_q;
      if (mq_q[0]) begin
         // counter 0 marks the multiplier sign bit, whose weight is negative
         if (cnt_q == '0) sum_d = acc_q - a_ext;
         else             sum_d = acc_q + a_ext;
      end
      acc_d = {sum_d[width], sum_d[width:1]};
      mq_d  = {sum_d[0], mq_q[width-1:1]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         mq_q      <= '0;
         a_q       <= '0;
         cnt_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         resultlow <= '0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= A;
                  mq_q    <= M;
                  acc_q   <= '0;
                  cnt_q   <= CW'(width - 1);
                  busy    <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  acc_q <= acc_d;
                  mq_q  <= mq_d;
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == '0) begin
                     // {acc_d, mq_d} is the full product; the MSB pair of the high word
                     // only disagrees for (-2^(w-1))^2, the one unrepresentable case
                     result    <= {acc_d[width-2:0], mq_d[width-1]};
                     resultlow <= {acc_d[width-2], mq_d[width-2:0]};
                     overflow  <= acc_d[width-1] ^ acc_d[width-2];
                     zero      <= (acc_d == '0) && (mq_d == '0);
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_q   <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_kv10_mul.sv
// tb/tb_kv10_mul.sv - directed and random self-checking bench for kv10_mul
module tb_kv10_mul;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [35:0] A = '0;
   logic [35:0] M = '0;
   logic        busy, done, overflow, zero;
   logic [35:0] result, resultlow;

   int tests = 0;
   int fails = 0;

   kv10_mul dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .A(A), .M(M), .busy(busy), .done(done),
      .result(result), .resultlow(resultlow), .overflow(overflow), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic do_start(input logic [35:0] a, input logic [35:0] m);
      @(negedge clk);
      A = a; M = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = 36'o525252525252; M = 36'o252525252525;
   endtask

   // counts negedges until done, noting whether busy stayed high meanwhile
   task automatic wait_done(output int n, output bit busy_ok);
      n = 0; busy_ok = 1'b1;
      while (!done && n < 60) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; A = 36'd3; M = 36'd5;
      repeat (2) @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL reset_vs_start: busy=%b required 0", busy);
      end
      start = 1'b0; reset = 1'b0;
      @(negedge clk);
      tests++;
      if ({busy, done, overflow, zero, result, resultlow} !== 76'd0) begin
         fails++;
         $display("FAIL reset_state: busy=%b done=%b ov=%b z=%b hi=%o lo=%o required all 0",
                  busy, done, overflow, zero, result, resultlow);
      end
   endtask

   task automatic test_directed();
      logic [35:0] ta [6] = '{36'd3, 36'o777777777777, 36'o777777777777,
                              36'o377777777777, 36'o400000000000, 36'd0};
      logic [35:0] tm [6] = '{36'd5, 36'o777777777777, 36'd1,
                              36'd2, 36'o400000000000, 36'o123456701234};
      logic [35:0] eh [6] = '{36'd0, 36'd0, 36'o777777777777,
                              36'd1, 36'o400000000000, 36'd0};
      logic [35:0] el [6] = '{36'o17, 36'd1, 36'o777777777777,
                              36'o377777777776, 36'o400000000000, 36'd0};
      logic        eo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic        ez [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int n; bit bok;
      for (int i = 0; i < 6; i++) begin
         do_start(ta[i], tm[i]);
         wait_done(n, bok);
         tests++;
         if (n !== 36 || !bok || busy !== 1'b0) begin
            fails++;
            $display("FAIL directed%0d_timing: cycles=%0d busy_ok=%0d busy_at_done=%b required 36/1/0",
                     i, n, bok, busy);
         end
         tests++;
         if ({result, resultlow, overflow, zero} !== {eh[i], el[i], eo[i], ez[i]}) begin
            fails++;
            $display("FAIL directed%0d_value: hi=%o lo=%o ov=%b z=%b required hi=%o lo=%o ov=%b z=%b",
                     i, result, resultlow, overflow, zero, eh[i], el[i], eo[i], ez[i]);
         end
         @(negedge clk);
         tests++;
         if (done !== 1'b0 || result !== eh[i]) begin
            fails++;
            $display("FAIL directed%0d_hold: done=%b hi=%o required done=0 hi=%o", i, done, result, eh[i]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int n; bit bok;
      do_start(36'd5, 36'd7);
      repeat (10) @(negedge clk);
      A = 36'd1; M = 36'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n, bok);
      tests++;
      if (n + 11 !== 36 || {result, resultlow} !== {36'd0, 36'o43}) begin
         fails++;
         $display("FAIL ignore_start: cycles=%0d hi=%o lo=%o required 36 0 43", n + 11, result, resultlow);
      end
   endtask

   task automatic test_back_to_back();
      int n, k; bit bok;
      do_start(36'd3, 36'd5);
      wait_done(n, bok);
      A = 36'd6; M = 36'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (!done && k < 60) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (k !== 37 || {result, resultlow} !== {36'd0, 36'o52}) begin
         fails++;
         $display("FAIL back_to_back: spacing=%0d hi=%o lo=%o required 37 0 52", k, result, resultlow);
      end
   endtask

   task automatic test_abort();
      int n; bit bok; bit seen;
      do_start(36'd3, 36'd5);
      wait_done(n, bok);
      do_start(36'd7, 36'd9);
      repeat (19) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL abort_mid: busy=%b done=%b required 0 0", busy, done);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      tests++;
      if (seen || {result, resultlow} !== {36'd0, 36'o17}) begin
         fails++;
         $display("FAIL abort_hold: done_seen=%0d hi=%o lo=%o required 0 0 17", seen, result, resultlow);
      end
      // abort on the very edge of the last step
      do_start(36'd7, 36'd9);
      repeat (35) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || {result, resultlow} !== {36'd0, 36'o17}) begin
         fails++;
         $display("FAIL abort_final: done=%b busy=%b hi=%o lo=%o required 0 0 0 17",
                  done, busy, result, resultlow);
      end
   endtask

   task automatic test_reset_mid();
      int n; bit bok;
      do_start(36'd7, 36'd9);
      wait_done(n, bok);
      do_start(36'o777777777776, 36'd3);
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({busy, done, overflow, zero, result, resultlow} !== 76'd0) begin
         fails++;
         $display("FAIL reset_mid: busy=%b done=%b ov=%b z=%b hi=%o lo=%o required all 0",
                  busy, done, overflow, zero, result, resultlow);
      end
      @(negedge clk);
      reset = 1'b0;
      do_start(36'o777777777776, 36'd3);
      wait_done(n, bok);
      tests++;
      if (n !== 36 || {result, resultlow} !== {36'o777777777777, 36'o777777777772}) begin
         fails++;
         $display("FAIL reset_restart: cycles=%0d hi=%o lo=%o required 36 777777777777 777777777772",
                  n, result, resultlow);
      end
   endtask

   task automatic test_random();
      logic [63:0] r;
      logic [35:0] a, m, eh, el;
      logic [71:0] p;
      logic        eo, ez;
      int n; bit bok;
      for (int i = 0; i < 1000; i++) begin
         r = {$urandom, $urandom}; a = r[35:0];
         r = {$urandom, $urandom}; m = r[35:0];
         if (i % 10 == 3) a = 36'o400000000000;
         if (i % 10 == 7) m = 36'o777777777777;
         if (i % 50 == 11) m = 36'o400000000000;
         p  = {{36{a[35]}}, a} * {{36{m[35]}}, m};
         eh = p[70:35];
         el = {p[70], p[34:0]};
         eo = (a == 36'o400000000000) && (m == 36'o400000000000);
         ez = (p == 72'd0);
         do_start(a, m);
         wait_done(n, bok);
         tests++;
         if (n !== 36 || {result, resultlow, overflow, zero} !== {eh, el, eo, ez}) begin
            fails++;
            $display("FAIL random%0d a=%o m=%o: cycles=%0d hi=%o lo=%o ov=%b z=%b required 36 %o %o %b %b",
                     i, a, m, n, result, resultlow, overflow, zero, eh, el, eo, ez);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
